// File: rtl/master_game_sm.sv
// Top-level game controller: start-button sync, maze-completion detect,
// per-second countdown, and timed WIN/TIMEOUT hold before returning to IDLE.
module master_game_sm #(
  parameter int unsigned TICKS_PER_SEC = 100_000_000,
  parameter int unsigned TIME_LIMIT    = 30,
  parameter int unsigned HOLD_SECS     = 5
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTNC,
  input  logic [3:0] MAZE_STATUS,
  output logic [1:0] MASTER_STATE,
  output logic [7:0] TIME_LEFT,
  output logic       SEC_TICK
);

  localparam int unsigned      PW         = $clog2(TICKS_PER_SEC);
  localparam longint unsigned  HOLD_TOTAL = 64'(HOLD_SECS) * 64'(TICKS_PER_SEC);
  localparam int unsigned      HW         = $clog2(HOLD_TOTAL);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [HW-1:0]    HOLD_LAST  = HW'(HOLD_TOTAL - 1);
  localparam logic [7:0]       TL_RELOAD  = 8'(TIME_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_MAZE    = 2'b01,
    S_WIN     = 2'b10,
    S_TIMEOUT = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [7:0]      time_q, time_d;
  logic            tick_q, tick_d;
  logic            b0, b1, b2;
  logic [3:0]      prev_status;
  logic            start_pulse;
  logic            win;

  assign start_pulse = b1 & ~b2;
  // Only a fresh transition into FINISHED counts; a status already at 4'hF stays inert.
  assign win = (MAZE_STATUS == 4'hF) && (prev_status != 4'hF) && (state_q == S_MAZE);

  assign MASTER_STATE = state_q;
  assign TIME_LEFT    = time_q;
  assign SEC_TICK     = tick_q;

  // Button synchroniser / edge detector and maze-status history.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      b0          <= 1'b0;
      b1          <= 1'b0;
      b2          <= 1'b0;
      prev_status <= 4'hF;
    end else begin
      b0          <= BTNC;
      b1          <= b0;
      b2          <= b1;
      prev_status <= MAZE_STATUS;
    end
  end

  // Controller state register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      hold_q  <= '0;
      time_q  <= TL_RELOAD;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      hold_q  <= hold_d;
      time_q  <= time_d;
      tick_q  <= tick_d;
    end
  end

  // Next-state, countdown and hold-timer logic.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    hold_d  = hold_q;
    time_d  = time_q;
    tick_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        presc_d = '0;
        hold_d  = '0;
        time_d  = TL_RELOAD;
        if (start_pulse) state_d = S_MAZE;
      end
      S_MAZE: begin
        hold_d = '0;
        // Win outranks a coincident final tick: no decrement, no pulse.
        if (win) begin
          state_d = S_WIN;
          presc_d = '0;
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          tick_d  = 1'b1;
          if (time_q <= 8'd1) begin
            time_d  = 8'd0;
            state_d = S_TIMEOUT;
          end else begin
            time_d = time_q - 8'd1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      S_WIN, S_TIMEOUT: begin
        presc_d = '0;
        if (start_pulse || (hold_q == HOLD_LAST)) begin
          state_d = S_IDLE;
          time_d  = TL_RELOAD;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        presc_d = '0;
        hold_d  = '0;
        time_d  = TL_RELOAD;
      end
    endcase
  end

endmodule

// File: tb/tb_master_game_sm.sv
// Scoreboard bench for master_game_sm (TICKS_PER_SEC=4, TIME_LIMIT=3, HOLD_SECS=2).
module tb_master_game_sm;

  localparam logic [1:0] IDLE = 2'b00, MAZE = 2'b01, WIN = 2'b10, TOUT = 2'b11;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       BTNC = 1'b0;
  logic [3:0] MAZE_STATUS = 4'h1;
  logic [1:0] MASTER_STATE;
  logic [7:0] TIME_LEFT;
  logic       SEC_TICK;

  typedef struct {
    int         test;
    int         idx;
    logic [1:0] st;
    logic [7:0] tl;
    logic       tk;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cur_test = 0;
  int   vec_idx = 0;
  int   btn_hold = 0;

  master_game_sm #(
    .TICKS_PER_SEC(4),
    .TIME_LIMIT(3),
    .HOLD_SECS(2)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .BTNC(BTNC),
    .MAZE_STATUS(MAZE_STATUS),
    .MASTER_STATE(MASTER_STATE),
    .TIME_LEFT(TIME_LEFT),
    .SEC_TICK(SEC_TICK)
  );

  always #5 CLK = ~CLK;

  // Monitor: one expected entry per clock edge, checked at the following falling edge.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      if (MASTER_STATE !== e.st || TIME_LEFT !== e.tl || SEC_TICK !== e.tk) begin
        miscompares++;
        $display("FAIL test%0d vec%0d: got state=%b time=%0d tick=%b, expected state=%b time=%0d tick=%b",
                 e.test, e.idx, MASTER_STATE, TIME_LEFT, SEC_TICK, e.st, e.tl, e.tk);
      end
    end
  end

  // One clock edge of stimulus; expectation describes outputs after that edge.
  task automatic step(input logic rst, input logic [3:0] status,
                      input logic [1:0] est, input logic [7:0] etl, input logic etk);
    exp_t e;
    @(negedge CLK);
    RESET       = rst;
    MAZE_STATUS = status;
    BTNC        = (btn_hold > 0);
    if (btn_hold > 0) btn_hold--;
    @(posedge CLK);
    e.test = cur_test;
    e.idx  = vec_idx;
    e.st   = est;
    e.tl   = etl;
    e.tk   = etk;
    vec_idx++;
    exp_q.push_back(e);
  endtask

  // Single-cycle button press from IDLE: MAZE appears on the third edge.
  task automatic start_game(input logic [3:0] status);
    btn_hold = 1;
    step(1'b0, status, IDLE, 8'd3, 1'b0);
    step(1'b0, status, IDLE, 8'd3, 1'b0);
    step(1'b0, status, MAZE, 8'd3, 1'b0);
  endtask

  // Runs 'secs' countdown seconds from entry; optionally status goes 4'hF on the last edge.
  task automatic run_maze(input logic [3:0] status, input int secs, input logic win_last);
    for (int s = 0; s < secs; s++) begin
      logic [7:0] tl;
      tl = 8'(3 - s);
      for (int k = 0; k < 3; k++) step(1'b0, status, MAZE, tl, 1'b0);
      if (s == secs - 1 && win_last)
        step(1'b0, 4'hF, WIN, tl, 1'b0);
      else if (tl == 8'd1)
        step(1'b0, status, TOUT, 8'd0, 1'b1);
      else
        step(1'b0, status, MAZE, tl - 8'd1, 1'b1);
    end
  endtask

  // Full hold in a result state then automatic return to IDLE.
  task automatic full_hold(input logic [3:0] status, input logic [1:0] rs, input logic [7:0] tl);
    for (int k = 0; k < 7; k++) step(1'b0, status, rs, tl, 1'b0);
    step(1'b0, status, IDLE, 8'd3, 1'b0);
  endtask

  initial begin
    // Test 1/2: held button gives one start; countdown to TIMEOUT, auto-return.
    cur_test = 1;
    step(1'b1, 4'h1, IDLE, 8'd3, 1'b0);
    step(1'b1, 4'h1, IDLE, 8'd3, 1'b0);
    btn_hold = 10;
    step(1'b0, 4'h1, IDLE, 8'd3, 1'b0);
    step(1'b0, 4'h1, IDLE, 8'd3, 1'b0);
    step(1'b0, 4'h1, MAZE, 8'd3, 1'b0);
    cur_test = 2;
    run_maze(4'h1, 3, 1'b0);
    full_hold(4'h1, TOUT, 8'd0);

    // Test 3: win with TIME_LEFT=2, button aborts the hold.
    cur_test = 3;
    start_game(4'h1);
    run_maze(4'h1, 1, 1'b0);
    step(1'b0, 4'h8, MAZE, 8'd2, 1'b0);
    step(1'b0, 4'hF, WIN, 8'd2, 1'b0);
    btn_hold = 1;
    step(1'b0, 4'hF, WIN, 8'd2, 1'b0);
    step(1'b0, 4'hF, WIN, 8'd2, 1'b0);
    step(1'b0, 4'hF, IDLE, 8'd3, 1'b0);

    // Test 4: win coincides with the final tick.
    cur_test = 4;
    step(1'b1, 4'h1, IDLE, 8'd3, 1'b0);
    start_game(4'h1);
    run_maze(4'h1, 3, 1'b1);
    full_hold(4'hF, WIN, 8'd1);

    // Test 5: status already FINISHED on entry never wins.
    cur_test = 5;
    start_game(4'hF);
    run_maze(4'hF, 3, 1'b0);
    btn_hold = 1;
    step(1'b0, 4'hF, TOUT, 8'd0, 1'b0);
    step(1'b0, 4'hF, TOUT, 8'd0, 1'b0);
    step(1'b0, 4'hF, IDLE, 8'd3, 1'b0);

    // Test 6: reset mid-game.
    cur_test = 6;
    start_game(4'h1);
    run_maze(4'h1, 1, 1'b0);
    step(1'b0, 4'h1, MAZE, 8'd2, 1'b0);
    step(1'b1, 4'h1, IDLE, 8'd3, 1'b0);
    step(1'b0, 4'h1, IDLE, 8'd3, 1'b0);

    @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
